aes_128_decrypt_iter: RTL and testbench

Iterative AES-128 inverse cipher (FIPS-197 decryption), one round per clock, with valid/ready handshakes on input and output. It is the receive-side counterpart to the pipelined `aes_128` encryptor: ciphertext produced by `aes_128` under a key is returned to plaintext here. The block derives the round-10 key by forward expansion, then runs the inverse key schedule backwards alongside the rounds. It caches the last key's round-10 key so that repeated blocks under the same key skip expansion.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_sbox.sv | 25 ++
 rtl/inv_sbox.sv | 25 ++
 rtl/aes_128_decrypt_iter.sv | 144 ++++++++++++++
 tb/tb_aes_128_decrypt_iter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-128 inverse cipher.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_e;

  // Byte 0 of a block sits at bits [127:120]; word 0 of a key at [127:96].
  typedef logic [0:15][7:0] blk_t;
  typedef logic [0:3][31:0] kw_t;

  localparam logic [10:1][7:0] RCON = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                       8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [3:0] bidx(input int r, input int c);
    return 4'(r + 4 * c);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, combinational table lookup.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  assign y_o = SBOX[a_i];
endmodule

// File: rtl/inv_sbox.sv
// Inverse AES S-box, combinational table lookup.
module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] ISBOX = {
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  assign y_o = ISBOX[a_i];
endmodule

// File: rtl/aes_128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: forward key expansion to rk10 (cached per key),
// then ten inverse rounds with the key schedule run backwards alongside.
module aes_128_decrypt_iter
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  fsm_e         fsm_q;
  logic [127:0] s_q, k_q, out_q;
  logic [127:0] cache_key_q, cache_rk_q;
  logic         cache_vld_q, in_ready_q, out_valid_q;
  logic [3:0]   rc_q;

  kw_t          kw, kfwd, kinv;
  logic [31:0]  sb_in, sb_rot, sb_out;
  logic [7:0]   rcon_b;
  blk_t         sb, isr, isb, ark, imc;
  logic [127:0] round_d;
  logic         cache_hit;

  assign kw        = k_q;
  assign rcon_b    = RCON[rc_q + 4'd1];
  assign cache_hit = cache_vld_q && (key == cache_key_q);

  // The four forward S-boxes serve both schedules: w3 while expanding, w3^w2 while inverting.
  assign sb_in  = (fsm_q == ROUND) ? (kw[3] ^ kw[2]) : kw[3];
  assign sb_rot = rot_word(sb_in);

  for (genvar j = 0; j < 4; j++) begin : g_ksb
    aes_sbox u_sbox (.a_i(sb_rot[31-8*j -: 8]), .y_o(sb_out[31-8*j -: 8]));
  end

  assign kfwd[0] = kw[0] ^ sb_out ^ {rcon_b, 24'h0};
  assign kfwd[1] = kfwd[0] ^ kw[1];
  assign kfwd[2] = kfwd[1] ^ kw[2];
  assign kfwd[3] = kfwd[2] ^ kw[3];

  assign kinv[3] = kw[3] ^ kw[2];
  assign kinv[2] = kw[2] ^ kw[1];
  assign kinv[1] = kw[1] ^ kw[0];
  assign kinv[0] = kw[0] ^ sb_out ^ {rcon_b, 24'h0};

  assign sb = s_q;

  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int R = i % 4;
    localparam int C = i / 4;
    assign isr[i] = sb[bidx(R, (C - R + 4) % 4)];
    inv_sbox u_isb (.a_i(isr[i]), .y_o(isb[i]));
  end

  assign ark = isb ^ kinv;

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = ark[4*c];
    assign a1 = ark[4*c+1];
    assign a2 = ark[4*c+2];
    assign a3 = ark[4*c+3];
    assign imc[4*c]   = gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3);
    assign imc[4*c+1] = gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3);
    assign imc[4*c+2] = gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3);
    assign imc[4*c+3] = gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3);
  end

  assign round_d = (rc_q == 4'd0) ? ark : imc;

  // In ROUND, rc_q holds the round number r, counting down from 9.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      s_q         <= '0;
      k_q         <= '0;
      rc_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      cache_rk_q  <= '0;
    end else begin
      case (fsm_q)
        IDLE: if (in_valid) begin
          in_ready_q <= 1'b0;
          if (cache_hit) begin
            s_q   <= state ^ cache_rk_q;
            k_q   <= cache_rk_q;
            rc_q  <= 4'd9;
            fsm_q <= ROUND;
          end else begin
            s_q         <= state;
            k_q         <= key;
            rc_q        <= '0;
            cache_key_q <= key;
            cache_vld_q <= 1'b0;
            fsm_q       <= KEYEXP;
          end
        end
        KEYEXP: begin
          k_q  <= kfwd;
          rc_q <= rc_q + 4'd1;
          if (rc_q == 4'd9) begin
            s_q         <= s_q ^ kfwd;
            cache_rk_q  <= kfwd;
            cache_vld_q <= 1'b1;
            rc_q        <= 4'd9;
            fsm_q       <= ROUND;
          end
        end
        ROUND: begin
          k_q  <= kinv;
          s_q  <= round_d;
          rc_q <= rc_q - 4'd1;
          if (rc_q == 4'd0) begin
            rc_q        <= '0;
            out_q       <= round_d;
            out_valid_q <= 1'b1;
            fsm_q       <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          fsm_q       <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_aes_128_decrypt_iter.sv
// Scoreboard bench for aes_128_decrypt_iter using FIPS-197 known-answer vectors.
module tb_aes_128_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out;

  aes_128_decrypt_iter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state(state), .key(key), .out_valid(out_valid), .out_ready(out_ready), .out(out)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  typedef struct {
    logic [127:0] pt;
    int           lat;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Monitor: pops one expectation the first cycle each result is presented.
  always @(negedge clk) begin
    if (!rst_n) seen = 0;
    else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out: got %h with nothing outstanding", out);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("plaintext", out, e.pt);
          chk("latency", 128'(cyc - e.acc), 128'(e.lat));
        end
      end
      if (out_ready) seen = 0;
    end
  end

  task automatic send(input logic [127:0] k, input logic [127:0] ct,
                      input logic [127:0] pt, input int lat, input bit track);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail("send_wait_in_ready");
      return;
    end
    key = k;
    state = ct;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    key = '0;
    state = '0;
    if (track) q.push_back('{pt, lat, cyc});
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q.size() == 0 && in_ready && !out_valid) && n < 100);
    if (!(q.size() == 0 && in_ready && !out_valid)) fail("drain");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", 128'(in_ready), 128'd1);
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_out", out, 128'd0);
    rst_n = 1'b1;

    send(K1, CT1, PT1, 20, 1);   drain();
    send(K2, CT2, PT2, 20, 1);   drain();
    send(K2, CT2, PT2, 10, 1);   drain();
    send('0, CT0, '0, 20, 1);    drain();
    send(K1, CT1, PT1, 20, 1);   drain();

    // Backpressure: hold the result while in_valid keeps poking.
    out_ready = 1'b0;
    send(K1, CT1, PT1, 10, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    if (!out_valid) fail("bp_wait_out_valid");
    repeat (7) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      key = K2;
      state = CT2;
      @(negedge clk);
      chk("bp_out_stable", out, PT1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 128'(out_valid), 128'd1);
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'd1);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    drain();

    // Reset in the middle of a cache-hit decryption.
    send(K1, CT1, PT1, 10, 0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_out", out, 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    send(K1, CT1, PT1, 20, 1);   drain();

    // A few back-to-back transfers with random idle gaps.
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(K2, CT2, PT2, (i == 0) ? 20 : 10, 1);
    end
    drain();

    chk("queue_empty", 128'(q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
